// File: rtl/alu_rr_arbiter_if.sv
// Requester-side bus of the ALU arbiter: packed per-requester request
// channel plus the shared response channel.
interface alu_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int RES_W  = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic [N_REQ-1:0]        resp_valid;
    logic [N_REQ-1:0]        resp_ready;
    logic [RES_W-1:0]        resp_result;
    logic                    resp_error;

    // Requesters / stimulus driver
    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_error
    );

    // Arbiter
    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_error
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among N_REQ requesters.
// One operation in flight: accept -> start pulse -> wait done (with
// watchdog) -> return result to the granted requester.
module alu_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_rr_arbiter_if.slave          bus,
    output logic                     alu_start,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic                     alu_done,
    input  logic [RES_W-1:0]         alu_result,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int GW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GW-1:0]    LAST_INIT = GW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [GW-1:0]     last;
    logic [CNT_W-1:0]  cnt;

    logic              found;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     idx;
    logic [DATA_W-1:0] pick_a;
    logic [DATA_W-1:0] pick_b;
    logic [OP_W-1:0]   pick_op;
    logic              req_hs;

    // Round-robin search starting just after the last served requester
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = GW'((32'(last) + 32'(i) + 32'd1) % 32'(N_REQ));
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Operand mux for the selected requester's slice
    always_comb begin
        pick_a  = '0;
        pick_b  = '0;
        pick_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (GW'(i) == pick) begin
                pick_a  = bus.req_a[i*DATA_W +: DATA_W];
                pick_b  = bus.req_b[i*DATA_W +: DATA_W];
                pick_op = bus.req_op[i*OP_W +: OP_W];
            end
        end
    end

    // Accept is combinational so the grant and handshake share one IDLE cycle
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found && !rst) begin
            bus.req_ready[pick] = 1'b1;
        end
    end

    assign req_hs = |(bus.req_valid & bus.req_ready);

    // Arbitration FSM with registered ALU and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last            <= LAST_INIT;
            cnt             <= '0;
            alu_start       <= 1'b0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_op          <= '0;
            busy            <= 1'b0;
            grant_id        <= '0;
            bus.resp_valid  <= '0;
            bus.resp_result <= '0;
            bus.resp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        alu_a     <= pick_a;
                        alu_b     <= pick_b;
                        alu_op    <= pick_op;
                        grant_id  <= pick;
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_start <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done takes priority over a watchdog expiring in the same cycle
                    if (alu_done) begin
                        bus.resp_result          <= alu_result;
                        bus.resp_error           <= 1'b0;
                        bus.resp_valid           <= '0;
                        bus.resp_valid[grant_id] <= 1'b1;
                        state                    <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.resp_result          <= '0;
                        bus.resp_error           <= 1'b1;
                        bus.resp_valid           <= '0;
                        bus.resp_valid[grant_id] <= 1'b1;
                        state                    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready[grant_id]) begin
                        bus.resp_valid <= '0;
                        last           <= grant_id;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: stimulus pushes expected responses into
// a scoreboard, a monitor pops and compares on each response handshake.
module tb_alu_rr_arbiter;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int RES_W   = 16;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_start;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_done;
    logic [RES_W-1:0]  alu_result;
    logic              busy;
    logic [1:0]        grant_id;

    alu_rr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W)) bus ();

    alu_rr_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int alu_delay = 1;   // cycles from start to done; 0 = never

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ALU model: op 0 adds, anything else concatenates operands
    initial begin
        alu_done   = 1'b0;
        alu_result = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (alu_start && alu_delay > 0) begin
                for (int k = 1; k <= alu_delay; k++) begin
                    @(posedge clk); #1;
                end
                alu_done   = 1'b1;
                alu_result = (alu_op == 3'd0) ? 16'(alu_a) + 16'(alu_b) : {alu_a, alu_b};
                @(posedge clk); #1;
                alu_done   = 1'b0;
                alu_result = 16'hDEAD;
            end
        end
    end

    // Monitor: compare every response handshake against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.resp_valid & bus.resp_ready) != '0) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got resp_valid 0x%0h, expected no response", bus.resp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valid", 32'(bus.resp_valid), 32'(1 << e.id));
                    chk("resp_result", 32'(bus.resp_result), 32'(e.res));
                    chk("resp_error", 32'(bus.resp_error), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_start(output int c);
        c = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (alu_start) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("start_seen", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output int c, output int busy_low);
        c = -1;
        busy_low = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (bus.resp_valid != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("resp_seen", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_seen", 32'd0, 32'd1);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.req_a[i*8 +: 8]  = a;
        bus.req_b[i*8 +: 8]  = b;
        bus.req_op[i*3 +: 3] = op;
        bus.req_valid[i]     = 1'b1;
    endtask

    // Single request with handshake check; arbiter must be idle
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input bit push, input logic [15:0] res, input logic err, output int h);
        @(posedge clk); #1;
        set_req(i, a, b, op);
        if (push) sb.push_back('{i, res, err});
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'(1 << i));
        h = cyc;
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    int h, s, c, bl, n_resp, n_busy, n_start;
    int order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 2};

    initial begin
        // Reset with a pending request: nothing may be accepted
        rst            = 1'b1;
        bus.req_valid  = 4'b0001;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_ctrl", 32'({bus.resp_valid, alu_start, busy, bus.resp_error, grant_id}), 32'd0);
        chk("rst_alu_in", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk("rst_result", 32'(bus.resp_result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // Single request: 255+255, done 5 cycles after start
        alu_delay = 5;
        issue(0, 8'd255, 8'd255, 3'd0, 1'b1, 16'd510, 1'b0, h);
        wait_start(s);
        chk("start_latency", 32'(s - h), 32'd1);
        chk("issue_operands", 32'({alu_a, alu_b, alu_op}), 32'({8'd255, 8'd255, 3'd0}));
        chk("issue_grant", 32'(grant_id), 32'd0);
        wait_resp(c, bl);
        chk("single_latency", 32'(c - h), 32'd7);
        wait_idle();

        // Fairness from a fresh pointer, then wrap-around search
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        alu_delay = 1;
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 8'(8'h20 + i), 3'd1);
        for (int k = 0; k < 9; k++)
            sb.push_back('{order[k], {8'(8'h10 + order[k]), 8'(8'h20 + order[k])}, 1'b0});
        for (int k = 0; k < 9; k++) begin
            wait_start(s);
            chk("rr_grant", 32'(grant_id), 32'(order[k]));
            if (k == 7) begin
                @(posedge clk); #1;
                bus.req_valid = 4'b0100;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // Timeout: ALU never answers
        alu_delay = 0;
        issue(3, 8'h5A, 8'hA5, 3'd2, 1'b1, 16'd0, 1'b1, h);
        wait_start(s);
        wait_resp(c, bl);
        chk("timeout_latency", 32'(c - s), 32'(TIMEOUT + 1));
        chk("timeout_busy_low", 32'(bl), 32'd0);
        wait_idle();

        // Done arrives in the watchdog's final cycle: result wins
        alu_delay = TIMEOUT;
        issue(1, 8'd3, 8'd4, 3'd0, 1'b1, 16'd7, 1'b0, h);
        wait_start(s);
        wait_resp(c, bl);
        chk("tie_latency", 32'(c - s), 32'(TIMEOUT + 1));
        wait_idle();

        // Backpressure with requester 1 waiting
        alu_delay = 2;
        @(posedge clk); #1;
        bus.resp_ready = '0;
        issue(2, 8'h11, 8'h22, 3'd1, 1'b1, 16'h1122, 1'b0, h);
        set_req(1, 8'h33, 8'h44, 3'd1);
        sb.push_back('{1, 16'h3344, 1'b0});
        wait_resp(c, bl);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", 32'({bus.resp_valid, bus.resp_result, bus.resp_error, bus.req_ready}),
                32'({4'b0100, 16'h1122, 1'b0, 4'b0000}));
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resp_ready = 4'b1111;
        @(negedge clk);
        h = cyc;
        @(negedge clk);
        chk("bp_regrant", 32'(bus.req_ready), 32'b0010);
        chk("bp_regrant_cycle", 32'(cyc - h), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // Reset during WAIT; the late done pulse must be ignored
        alu_delay = 8;
        issue(3, 8'd1, 8'd2, 3'd0, 1'b0, 16'd0, 1'b0, h);
        wait_start(s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_resp = 0;
        n_busy = 0;
        n_start = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) n_resp++;
            if (busy) n_busy++;
            if (alu_start) n_start++;
        end
        chk("abort_no_resp", 32'(n_resp), 32'd0);
        chk("abort_idle", 32'(n_busy + n_start), 32'd0);
        @(posedge clk); #1;
        set_req(0, 8'd9, 8'd1, 3'd0);
        set_req(3, 8'd2, 8'd2, 3'd1);
        sb.push_back('{0, 16'd10, 1'b0});
        sb.push_back('{3, 16'h0202, 1'b0});
        @(negedge clk);
        chk("abort_first_grant", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_start(s);
        chk("abort_grant0", 32'(grant_id), 32'd0);
        wait_start(s);
        chk("abort_grant3", 32'(grant_id), 32'd3);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
